alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the lab ALU; datapath width W is a parameter.
- Adds variable-amount shifts, executed one bit per clock, and an iterative shift-add multiply.
- Outputs and flags (carry/shift-out, branch, zero) are registered and hold until the next completion.
- Controlled by a START/BUSY/DONE handshake from the control unit; it sits between the register file read ports and the writeback/branch logic.

Parameters:
- W, 8, datapath width; must be even and >= 4.
- SAW, $clog2(W), width of the shift-amount field taken from INPUTA.

Ports:
- Clk  in  1  system clock; everything updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- START  in  1  request; sampled only in IDLE.
- OP  in  4  opcode; sampled with START.
- INPUTA  in  W  operand A; shift amount is INPUTA[SAW-1:0]. Sampled with START.
- INPUTB  in  W  operand B / shift source. Sampled with START.
- SC_IN  in  1  shift-in bit for SLO; sampled with START.
- BUSY  out  1  high while an iterative op is in progress.
- DONE  out  1  one-cycle pulse marking new results.
- OUT  out  W  result.
- SC_OUT  out  1  carry, borrow or last shifted-out bit.
- BR_FLAG  out  1  branch-taken flag.
- ZERO  out  1  high when OUT == 0, registered together with OUT.

Behaviour:
- Reset: state=IDLE, and BUSY, DONE, OUT, SC_OUT, BR_FLAG, ZERO all 0. Reset mid-operation aborts the op, emits no DONE, and discards the operands.
- States:
  - IDLE: START=1 at edge E0 accepts the op and captures OP/INPUTA/INPUTB/SC_IN.
  - EXEC: one step per edge; counter cnt counts remaining steps.
  - Transitions: IDLE->EXEC on an iterative op with n>0 steps. EXEC->IDLE at the final step edge En. Single-cycle ops stay in IDLE.
- Single-cycle ops (and shifts with amount 0): OUT/flags/ZERO update and DONE=1 at E0. BUSY never rises.
- Iterative ops with n steps: BUSY=1 from E0. Steps occur at E1..En. At En, OUT/flags/ZERO update, DONE=1 and BUSY=0.
- DONE is high for exactly one cycle.
- START while BUSY is ignored, with no queueing. START in the DONE cycle is accepted, giving back-to-back ops.
- Between completions all outputs hold; BR_FLAG is not cleared by non-branch ops until their completion rewrites it.
- OP encoding (unsigned arithmetic unless noted). Unless stated otherwise, SC_OUT=0 and BR_FLAG=0.
  - 0 ADD: {SC_OUT,OUT}=A+B, W+1-bit.
  - 1 SUB: OUT=A-B mod 2^W; SC_OUT=1 iff A<B (borrow).
  - 2 XOR: OUT=A^B.
  - 3 NOT: OUT=~B.
  - 4 SRA, 5 SRL, 6 SLL, 7 SLO: shift B by amt=A[SAW-1:0] bits, one bit per step, n=amt. SRA replicates B's MSB (signed). SRL/SLL fill 0. SLO fills SC_IN at every step. SC_OUT = last bit shifted out, or 0 if amt=0.
  - 8 BL: BR_FLAG=(A<B) unsigned; OUT=0.
  - 9 BR: BR_FLAG=1; OUT=0.
  - A BMH: BR_FLAG=(A[W-1:W/2]==B[W-1:W/2]); OUT=0.
  - B MUL: shift-add, n=W steps. OUT = low W bits of A*B; SC_OUT = OR of the high W bits (overflow).
  - C-F: illegal; single-cycle; OUT=0, all flags 0, ZERO=1, DONE pulses.
- ZERO is computed from the new OUT at every completion, including branch ops (OUT=0 gives ZERO=1).
- Operand changes after E0 have no effect on an op in flight.

Test Plan:
- W=8. Hold Reset 2 cycles, then START MUL 0x0D*0x15. Assert Reset at step 4 for 1 cycle -> all outputs 0, no DONE, BUSY=0. Then MUL 0x0D*0x15 -> DONE exactly 8 edges after accept, OUT=0x11, SC_OUT=1, ZERO=0.
- ADD 0xF0+0x20 -> DONE on the accepting edge, BUSY stays 0, OUT=0x10, SC_OUT=1. SUB 0x05-0x07 -> OUT=0xFE, SC_OUT=1.
- SRA B=0x90, A=0x05 -> BUSY high 5 cycles, OUT=0xFC, SC_OUT=1. SRL same operands -> OUT=0x04, SC_OUT=1. SLO B=0x81, A=0x02, SC_IN=1 -> OUT=0x07, SC_OUT=0. SLL amt 0, B=0x5A -> single-cycle, OUT=0x5A, SC_OUT=0.
- During MUL, pulse START with ADD at steps 2 and 5 -> ignored, MUL result unchanged. START ADD 0x01+0x01 in the MUL DONE cycle -> accepted, next DONE one cycle later, OUT=0x02.
- BMH 0x3A vs 0x35 -> BR_FLAG=1, ZERO=1. BL 0x80 vs 0x7F -> BR_FLAG=0. BL 0x7F vs 0x80 -> 1. BR -> 1. Following XOR 0xFF^0xFF -> BR_FLAG=0, OUT=0x00, ZERO=1.
- Illegal OP 0xE after a result with SC_OUT=1 -> DONE pulses, OUT=0, SC_OUT=0, BR_FLAG=0, ZERO=1.

Source files
------------

// File: rtl/alu_mc_if.sv
// alu_mc handshake and operand/result bundle.
// The control unit holds the master side; the ALU holds the slave side.
interface alu_mc_if #(
   parameter int W = 8
);
   logic         START;
   logic [3:0]   OP;
   logic [W-1:0] INPUTA;
   logic [W-1:0] INPUTB;
   logic         SC_IN;
   logic         BUSY;
   logic         DONE;
   logic [W-1:0] OUT;
   logic         SC_OUT;
   logic         BR_FLAG;
   logic         ZERO;

   modport master (
      output START, OP, INPUTA, INPUTB, SC_IN,
      input  BUSY, DONE, OUT, SC_OUT, BR_FLAG, ZERO
   );

   modport slave (
      input  START, OP, INPUTA, INPUTB, SC_IN,
      output BUSY, DONE, OUT, SC_OUT, BR_FLAG, ZERO
   );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/branch ops,
// bit-serial shifts and a shift-add multiply behind START/BUSY/DONE.
module alu_mc #(
   parameter int W   = 8,
   parameter int SAW = $clog2(W)
) (
   input logic     Clk,
   input logic     Reset,
   alu_mc_if.slave bus
);
   localparam int CW = $clog2(W) + 1;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_XOR = 4'h2;
   localparam logic [3:0] OP_NOT = 4'h3;
   localparam logic [3:0] OP_SRA = 4'h4;
   localparam logic [3:0] OP_SRL = 4'h5;
   localparam logic [3:0] OP_SLL = 4'h6;
   localparam logic [3:0] OP_SLO = 4'h7;
   localparam logic [3:0] OP_BL  = 4'h8;
   localparam logic [3:0] OP_BR  = 4'h9;
   localparam logic [3:0] OP_BMH = 4'hA;
   localparam logic [3:0] OP_MUL = 4'hB;

   typedef enum logic {IDLE, EXEC} state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [3:0]     op_q, op_d;
   logic [W-1:0]   sh_q, sh_d;
   logic [2*W-1:0] mcd_q, mcd_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic           sc_in_q, sc_in_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [W-1:0]   out_q, out_d;
   logic           sc_q, sc_d;
   logic           br_q, br_d;
   logic           zero_q, zero_d;

   logic           fin;
   logic [W-1:0]   res;
   logic           res_sc;
   logic           res_br;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [SAW-1:0] amt;
   logic [W-1:0]   step_sh;
   logic           step_bit;
   logic [2*W-1:0] acc_nx;

   assign a   = bus.INPUTA;
   assign b   = bus.INPUTB;
   assign amt = a[SAW-1:0];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      sh_d     = sh_q;
      mcd_d    = mcd_q;
      acc_d    = acc_q;
      sc_in_d  = sc_in_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      out_d    = out_q;
      sc_d     = sc_q;
      br_d     = br_q;
      zero_d   = zero_q;
      fin      = 1'b0;
      res      = '0;
      res_sc   = 1'b0;
      res_br   = 1'b0;
      step_sh  = sh_q;
      step_bit = 1'b0;
      acc_nx   = acc_q;
      if (state_q == IDLE) begin
         if (bus.START) begin
            fin     = 1'b1;
            op_d    = bus.OP;
            sh_d    = b;
            sc_in_d = bus.SC_IN;
            case (bus.OP)
               OP_ADD: {res_sc, res} = {1'b0, a} + {1'b0, b};
               OP_SUB: begin
                  res    = a - b;
                  res_sc = (a < b);
               end
               OP_XOR: res = a ^ b;
               OP_NOT: res = ~b;
               OP_SRA, OP_SRL, OP_SLL, OP_SLO: begin
                  if (amt != '0) begin
                     fin     = 1'b0;
                     cnt_d   = CW'(amt);
                     state_d = EXEC;
                     busy_d  = 1'b1;
                  end else begin
                     res = b;
                  end
               end
               OP_BL:  res_br = (a < b);
               OP_BR:  res_br = 1'b1;
               OP_BMH: res_br = (a[W-1:W/2] == b[W-1:W/2]);
               OP_MUL: begin
                  fin     = 1'b0;
                  cnt_d   = CW'(W);
                  state_d = EXEC;
                  busy_d  = 1'b1;
                  sh_d    = a;
                  mcd_d   = {{W{1'b0}}, b};
                  acc_d   = '0;
               end
               default: ;
            endcase
         end
      end else begin
         // sh_q is the shift source, or the multiplier for MUL
         case (op_q)
            OP_SRA: begin
               step_sh  = {sh_q[W-1], sh_q[W-1:1]};
               step_bit = sh_q[0];
            end
            OP_SRL: begin
               step_sh  = {1'b0, sh_q[W-1:1]};
               step_bit = sh_q[0];
            end
            OP_SLL: begin
               step_sh  = {sh_q[W-2:0], 1'b0};
               step_bit = sh_q[W-1];
            end
            OP_SLO: begin
               step_sh  = {sh_q[W-2:0], sc_in_q};
               step_bit = sh_q[W-1];
            end
            default: begin
               acc_nx  = sh_q[0] ? acc_q + mcd_q : acc_q;
               step_sh = {1'b0, sh_q[W-1:1]};
            end
         endcase
         sh_d  = step_sh;
         acc_d = acc_nx;
         mcd_d = mcd_q << 1;
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CW'(1)) begin
            fin     = 1'b1;
            state_d = IDLE;
            busy_d  = 1'b0;
            if (op_q == OP_MUL) begin
               res    = acc_nx[W-1:0];
               res_sc = |acc_nx[2*W-1:W];
            end else begin
               res    = step_sh;
               res_sc = step_bit;
            end
         end
      end
      if (fin) begin
         done_d = 1'b1;
         out_d  = res;
         sc_d   = res_sc;
         br_d   = res_br;
         zero_d = (res == '0);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         sh_q    <= '0;
         mcd_q   <= '0;
         acc_q   <= '0;
         sc_in_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         out_q   <= '0;
         sc_q    <= 1'b0;
         br_q    <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         sh_q    <= sh_d;
         mcd_q   <= mcd_d;
         acc_q   <= acc_d;
         sc_in_q <= sc_in_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         out_q   <= out_d;
         sc_q    <= sc_d;
         br_q    <= br_d;
         zero_q  <= zero_d;
      end
   end

   assign bus.BUSY    = busy_q;
   assign bus.DONE    = done_q;
   assign bus.OUT     = out_q;
   assign bus.SC_OUT  = sc_q;
   assign bus.BR_FLAG = br_q;
   assign bus.ZERO    = zero_q;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (W=8): directed vectors from hand-derived values
// plus random ops checked against an arithmetic reference model.
module tb_alu_mc;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   alu_mc_if #(.W(8)) bus ();
   alu_mc #(.W(8)) dut (.Clk(clk), .Reset(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] out;
      logic       sc;
      logic       br;
      logic       zero;
      int         n;
   } exp_t;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic       scin;
      logic [7:0] out;
      logic       sc;
      logic       br;
      logic       zero;
      int         n;
   } vec_t;

   function automatic exp_t model(logic [3:0] op, logic [7:0] a,
                                  logic [7:0] b, logic scin);
      exp_t e;
      int amt;
      int sum;
      logic [15:0] p;
      amt = int'(a[2:0]);
      e.out = 8'h00; e.sc = 1'b0; e.br = 1'b0; e.n = 0;
      case (op)
         4'h0: begin
            sum = int'(a) + int'(b);
            e.out = sum[7:0];
            e.sc = (sum > 255);
         end
         4'h1: begin e.out = a - b; e.sc = (a < b); end
         4'h2: e.out = a ^ b;
         4'h3: e.out = ~b;
         4'h4, 4'h5: begin
            e.out = (op == 4'h4) ? 8'($signed(b) >>> amt) : (b >> amt);
            e.sc = (amt > 0) ? b[amt-1] : 1'b0;
            e.n = amt;
         end
         4'h6, 4'h7: begin
            e.out = b << amt;
            if (op == 4'h7 && scin) e.out = e.out | 8'((1 << amt) - 1);
            e.sc = (amt > 0) ? b[8-amt] : 1'b0;
            e.n = amt;
         end
         4'h8: e.br = (a < b);
         4'h9: e.br = 1'b1;
         4'hA: e.br = (a[7:4] == b[7:4]);
         4'hB: begin
            p = 16'(a) * 16'(b);
            e.out = p[7:0];
            e.sc = |p[15:8];
            e.n = 8;
         end
         default: ;
      endcase
      e.zero = (e.out == 8'h00);
      return e;
   endfunction

   // Issues one op and measures edges from accept to DONE (0 = same edge).
   task automatic do_op(input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic scin,
                        output int lat, output bit busy_bad);
      @(negedge clk);
      bus.START = 1'b1; bus.OP = op;
      bus.INPUTA = a; bus.INPUTB = b; bus.SC_IN = scin;
      @(posedge clk); #1;
      bus.START = 1'b0;
      bus.OP = 4'($urandom); bus.INPUTA = 8'($urandom);
      bus.INPUTB = 8'($urandom); bus.SC_IN = 1'($urandom);
      lat = 0; busy_bad = 1'b0;
      while (!bus.DONE && lat < 40) begin
         if (!bus.BUSY) busy_bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      if (bus.BUSY) busy_bad = 1'b1;
   endtask

   task automatic test_reset();
      int dones;
      bus.START = 1'b0; bus.OP = '0; bus.INPUTA = '0;
      bus.INPUTB = '0; bus.SC_IN = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({bus.BUSY, bus.DONE, bus.OUT, bus.SC_OUT, bus.BR_FLAG, bus.ZERO} !== 13'h0) begin
         failures++;
         $display("FAIL reset_state got=%h want=0",
                  {bus.BUSY, bus.DONE, bus.OUT, bus.SC_OUT, bus.BR_FLAG, bus.ZERO});
      end
      rst = 1'b0;
      @(negedge clk);
      bus.START = 1'b1; bus.OP = 4'hB; bus.INPUTA = 8'h0D; bus.INPUTB = 8'h15;
      @(posedge clk); #1;
      bus.START = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if ({bus.BUSY, bus.DONE, bus.OUT, bus.SC_OUT, bus.BR_FLAG, bus.ZERO} !== 13'h0) begin
         failures++;
         $display("FAIL abort_state got=%h want=0",
                  {bus.BUSY, bus.DONE, bus.OUT, bus.SC_OUT, bus.BR_FLAG, bus.ZERO});
      end
      dones = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus.DONE || bus.BUSY) dones++;
      end
      checks++;
      if (dones !== 0) begin
         failures++;
         $display("FAIL abort_no_done got=%0d want=0", dones);
      end
   endtask

   task automatic test_mul_plan();
      int lat;
      bit bb;
      do_op(4'hB, 8'h0D, 8'h15, 1'b0, lat, bb);
      checks++;
      if (lat !== 8 || bb) begin
         failures++;
         $display("FAIL mul_latency got=%0d busy_bad=%0d want=8", lat, bb);
      end
      checks++;
      if ({bus.OUT, bus.SC_OUT, bus.ZERO} !== {8'h11, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL mul_result got=%h want=%h",
                  {bus.OUT, bus.SC_OUT, bus.ZERO}, {8'h11, 1'b1, 1'b0});
      end
   endtask

   task automatic test_directed();
      vec_t v[13];
      int lat;
      bit bb;
      v[0]  = '{4'h0, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 0};
      v[1]  = '{4'h1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 0};
      v[2]  = '{4'h4, 8'h05, 8'h90, 1'b0, 8'hFC, 1'b1, 1'b0, 1'b0, 5};
      v[3]  = '{4'h5, 8'h05, 8'h90, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0, 5};
      v[4]  = '{4'h7, 8'h02, 8'h81, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 2};
      v[5]  = '{4'h6, 8'h08, 8'h5A, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 0};
      v[6]  = '{4'hA, 8'h3A, 8'h35, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0};
      v[7]  = '{4'h8, 8'h80, 8'h7F, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0};
      v[8]  = '{4'h8, 8'h7F, 8'h80, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0};
      v[9]  = '{4'h9, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0};
      v[10] = '{4'h2, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0};
      v[11] = '{4'h0, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 0};
      v[12] = '{4'hE, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 0};
      for (int i = 0; i < 13; i++) begin
         do_op(v[i].op, v[i].a, v[i].b, v[i].scin, lat, bb);
         checks++;
         if (lat !== v[i].n || bb) begin
            failures++;
            $display("FAIL dir%0d_latency got=%0d busy_bad=%0d want=%0d",
                     i, lat, bb, v[i].n);
         end
         checks++;
         if ({bus.OUT, bus.SC_OUT, bus.BR_FLAG, bus.ZERO} !==
             {v[i].out, v[i].sc, v[i].br, v[i].zero}) begin
            failures++;
            $display("FAIL dir%0d_result got=%h want=%h", i,
                     {bus.OUT, bus.SC_OUT, bus.BR_FLAG, bus.ZERO},
                     {v[i].out, v[i].sc, v[i].br, v[i].zero});
         end
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      bit bb;
      @(negedge clk);
      bus.START = 1'b1; bus.OP = 4'hB; bus.INPUTA = 8'h0D; bus.INPUTB = 8'h15;
      @(posedge clk); #1;
      bus.START = 1'b0;
      lat = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         bus.START = (k == 2 || k == 5);
         bus.OP = 4'h0; bus.INPUTA = 8'h33; bus.INPUTB = 8'h44;
         @(posedge clk); #1;
         bus.START = 1'b0;
         lat = k;
         if (bus.DONE) break;
      end
      checks++;
      if (lat !== 8 || {bus.OUT, bus.SC_OUT} !== {8'h11, 1'b1}) begin
         failures++;
         $display("FAIL ignore_start got lat=%0d res=%h want lat=8 res=%h",
                  lat, {bus.OUT, bus.SC_OUT}, {8'h11, 1'b1});
      end
      do_op(4'h0, 8'h01, 8'h01, 1'b0, lat, bb);
      checks++;
      if (lat !== 0 || bb || bus.OUT !== 8'h02) begin
         failures++;
         $display("FAIL back_to_back got lat=%0d out=%h want lat=0 out=02",
                  lat, bus.OUT);
      end
   endtask

   task automatic test_random();
      int lat;
      bit bb;
      exp_t e;
      logic [3:0] op;
      logic [7:0] a, b;
      logic scin;
      for (int i = 0; i < 80; i++) begin
         op = 4'($urandom_range(0, 15));
         a = 8'($urandom); b = 8'($urandom); scin = 1'($urandom);
         e = model(op, a, b, scin);
         do_op(op, a, b, scin, lat, bb);
         checks++;
         if (lat !== e.n || bb) begin
            failures++;
            $display("FAIL rnd%0d_latency op=%h got=%0d busy_bad=%0d want=%0d",
                     i, op, lat, bb, e.n);
         end
         checks++;
         if ({bus.OUT, bus.SC_OUT, bus.BR_FLAG, bus.ZERO} !==
             {e.out, e.sc, e.br, e.zero}) begin
            failures++;
            $display("FAIL rnd%0d_result op=%h a=%h b=%h got=%h want=%h",
                     i, op, a, b, {bus.OUT, bus.SC_OUT, bus.BR_FLAG, bus.ZERO},
                     {e.out, e.sc, e.br, e.zero});
         end
         if (i % 4 == 0) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.DONE, bus.BUSY, bus.OUT, bus.SC_OUT, bus.BR_FLAG, bus.ZERO} !==
                {2'b00, e.out, e.sc, e.br, e.zero}) begin
               failures++;
               $display("FAIL rnd%0d_hold got=%h want=%h", i,
                        {bus.DONE, bus.BUSY, bus.OUT, bus.SC_OUT, bus.BR_FLAG, bus.ZERO},
                        {2'b00, e.out, e.sc, e.br, e.zero});
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_mul_plan();
      test_directed();
      test_ignore_start();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
